// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C responder datapath.
package i2c_slave_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  // Level on SDA during the ninth clock of a byte
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Bit counter reload value (MSB index of a byte)
  localparam logic [2:0] CNT_TOP = 3'(I2C_BYTE_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_DATA,
    ST_RX_ACK,
    ST_TX_DATA,
    ST_TX_ACK,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_slave_line_sync.sv
// Synchronises raw SCL/SDA into the core clock domain and produces
// one-cycle registered pulses for SCL edges and START/STOP conditions.
// Pad edge to event pulse latency is SYNC_STAGES+1 core cycles.
module i2c_slave_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i2c_core_clock_i,
  input  logic reset_bit_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_level
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_prev;
  logic                   sda_prev;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // SDA value aligned with the registered event pulses
  assign sda_level = sda_prev;

  // Synchroniser chains, previous-value registers and registered events
  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
    if (!reset_bit_i) begin
      // NOTE: the chains reset to 1 (idle bus) so leaving reset never looks like an edge.
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_prev  <= 1'b1;
      sda_prev  <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a true shift chain.
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev  <= scl_s;
      sda_prev  <= sda_s;
      scl_rise  <= scl_s & ~scl_prev;
      scl_fall  <= ~scl_s & scl_prev;
      start_det <= scl_s & ~sda_s & sda_prev;
      stop_det  <= scl_s & sda_s & ~sda_prev;
    end
  end

endmodule

// File: rtl/i2c_slave_data_path_block.sv
// I2C responder datapath: address match, ACK generation, byte receive
// and byte transmit. All bus timing is taken from sampled SCL edges.
// Optional macro I2C_SLAVE_CLK_STRETCH_EN adds scl_o and holds SCL low
// while a transmit byte is missing; without it IDLE_FILL is sent.
module i2c_slave_data_path_block
  import i2c_slave_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [I2C_BYTE_W-1:0] IDLE_FILL   = 8'hFF
) (
  input  logic                  i2c_core_clock_i,
  input  logic                  reset_bit_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  input  logic [I2C_ADDR_W-1:0] slave_addr_i,
  input  logic [I2C_BYTE_W-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  sda_o,
  output logic [I2C_BYTE_W-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  rw_o,
  output logic                  addr_match_o,
  output logic                  stop_o,
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  output logic                  scl_o,
`endif
  output logic                  busy_o
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_level;

  i2c_slave_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .i2c_core_clock_i (i2c_core_clock_i),
    .reset_bit_i      (reset_bit_i),
    .scl_i            (scl_i),
    .sda_i            (sda_i),
    .scl_rise         (scl_rise),
    .scl_fall         (scl_fall),
    .start_det        (start_det),
    .stop_det         (stop_det),
    .sda_level        (sda_level)
  );

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [2:0]              cnt_m1;
  logic [I2C_BYTE_W-1:0]   shift_q, shift_d;
  logic [I2C_BYTE_W-1:0]   tx_byte_q, tx_byte_d;
  logic [I2C_BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                    ack_phase_q, ack_phase_d;
  logic                    sda_q, sda_d;
  logic                    rw_q, rw_d;
  logic                    busy_q, busy_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    addr_match_q, addr_match_d;
  logic                    tx_ready_q, tx_ready_d;
  logic                    stop_q, stop_d;
  logic                    load_due;
  logic                    load_wait;
  logic                    addr_hit;

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic pend_q, pend_d;
  logic hold_q, hold_d;
  assign load_wait = pend_q;
  assign scl_o     = ~hold_q;
`else
  assign load_wait = 1'b0;
`endif

  // After seven address rises the low seven shift bits hold the address
  assign addr_hit = (shift_q[I2C_ADDR_W-1:0] == slave_addr_i);
  assign cnt_m1   = cnt_q - 3'd1;

  // State register
  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
    if (!reset_bit_i) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic; START outranks STOP, which outranks bit events
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ST_ADDR;
    end else if (stop_det) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ADDR:     if (scl_rise && cnt_q == 3'd0) state_d = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK: if (scl_fall && ack_phase_q)   state_d = rw_q ? ST_TX_DATA : ST_RX_DATA;
        ST_RX_DATA:  if (scl_rise && cnt_q == 3'd0) state_d = ST_RX_ACK;
        ST_RX_ACK:   if (scl_fall && ack_phase_q)   state_d = ST_RX_DATA;
        ST_TX_DATA:  if (!load_wait && scl_fall && cnt_q == 3'd0) state_d = ST_TX_ACK;
        ST_TX_ACK: begin
          if (scl_rise && sda_level == NACK)   state_d = ST_IGNORE;
          else if (scl_fall && ack_phase_q)    state_d = ST_TX_DATA;
        end
        default: ;
      endcase
    end
  end

  // Output/datapath next values, registered below so sda_o is glitch-free
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    sda_d        = sda_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    tx_byte_d    = tx_byte_q;
    rx_data_d    = rx_data_q;
    ack_phase_d  = ack_phase_q;
    rw_d         = rw_q;
    busy_d       = busy_q;
    rx_valid_d   = 1'b0;
    addr_match_d = 1'b0;
    tx_ready_d   = 1'b0;
    stop_d       = 1'b0;
    load_due     = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    pend_d = pend_q;
    hold_d = hold_q;
    // SCL is let go one cycle after the late byte's MSB went onto SDA
    if (hold_q && !pend_q) hold_d = 1'b0;
`endif

    if (start_det || stop_det) begin
      sda_d       = 1'b1;
      cnt_d       = CNT_TOP;
      ack_phase_d = 1'b0;
      busy_d      = 1'b0;
      stop_d      = ~start_det;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      pend_d = 1'b0;
      hold_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[I2C_BYTE_W-2:0], sda_level};
            if (cnt_q == 3'd0) begin
              if (addr_hit) begin
                rw_d         = sda_level;
                addr_match_d = 1'b1;
                busy_d       = 1'b1;
              end
            end else begin
              cnt_d = cnt_m1;
            end
          end
        end
        ST_ADDR_ACK, ST_RX_ACK: begin
          // First fall drives ACK, second fall ends the ninth clock
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_d       = ACK;
              ack_phase_d = 1'b1;
            end else begin
              sda_d       = 1'b1;
              ack_phase_d = 1'b0;
              cnt_d       = CNT_TOP;
              load_due    = (state_q == ST_ADDR_ACK) && rw_q;
            end
          end
        end
        ST_RX_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[I2C_BYTE_W-2:0], sda_level};
            if (cnt_q == 3'd0) begin
              rx_data_d  = {shift_q[I2C_BYTE_W-2:0], sda_level};
              rx_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_m1;
            end
          end
        end
        ST_TX_DATA: begin
          if (load_wait) begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            if (tx_valid_i) begin
              tx_byte_d  = tx_data_i;
              tx_ready_d = 1'b1;
              sda_d      = tx_data_i[I2C_BYTE_W-1];
              pend_d     = 1'b0;
            end
`endif
          end else if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_d = 1'b1;
            end else begin
              cnt_d = cnt_m1;
              sda_d = tx_byte_q[cnt_m1];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            ack_phase_d = (sda_level == ACK);
          end else if (scl_fall && ack_phase_q) begin
            ack_phase_d = 1'b0;
            cnt_d       = CNT_TOP;
            load_due    = 1'b1;
          end
        end
        ST_IGNORE: sda_d = 1'b1;
        default: ;
      endcase
    end

    // Transmit byte load, shared by the address ACK exit and a master ACK
    if (load_due) begin
      if (tx_valid_i) begin
        tx_byte_d  = tx_data_i;
        tx_ready_d = 1'b1;
        sda_d      = tx_data_i[I2C_BYTE_W-1];
      end else begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        pend_d = 1'b1;
        hold_d = 1'b1;
        sda_d  = 1'b1;
`else
        tx_byte_d = IDLE_FILL;
        sda_d     = IDLE_FILL[I2C_BYTE_W-1];
`endif
      end
    end
  end

  // Datapath and output registers; reset releases SDA asynchronously
  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
    if (!reset_bit_i) begin
      sda_q        <= 1'b1;
      cnt_q        <= CNT_TOP;
      shift_q      <= '0;
      tx_byte_q    <= '0;
      rx_data_q    <= '0;
      ack_phase_q  <= 1'b0;
      rw_q         <= 1'b0;
      busy_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      addr_match_q <= 1'b0;
      tx_ready_q   <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      sda_q        <= sda_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      tx_byte_q    <= tx_byte_d;
      rx_data_q    <= rx_data_d;
      ack_phase_q  <= ack_phase_d;
      rw_q         <= rw_d;
      busy_q       <= busy_d;
      rx_valid_q   <= rx_valid_d;
      addr_match_q <= addr_match_d;
      tx_ready_q   <= tx_ready_d;
      stop_q       <= stop_d;
    end
  end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  // Clock-stretch bookkeeping
  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
    if (!reset_bit_i) begin
      pend_q <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      hold_q <= hold_d;
    end
  end
`endif

  assign sda_o        = sda_q;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign addr_match_o = addr_match_q;
  assign tx_ready_o   = tx_ready_q;
  assign stop_o       = stop_q;
  assign rw_o         = rw_q;
  assign busy_o       = busy_q;

endmodule

// File: doc/i2c_slave_data_path_block.md
Name: i2c_slave_data_path_block

Overview:
Responder-side I2C datapath for the other end of the master data path.
- Samples raw SCL/SDA, detects START/STOP and matches the 7-bit address.
- ACKs its address, shifts received bytes out to the core, and serialises transmit bytes onto SDA during master reads.
- Sits between the pad open-drain buffers and the slave register/FIFO logic; all timing is derived from sampled SCL, with no prescaler.

Parameters:
SYNC_STAGES, 2, synchroniser depth on scl_i/sda_i (min 2)
IDLE_FILL, 8'hFF, byte sent when a read byte is needed and tx_valid_i=0 (non-stretch build)

Ports:
i2c_core_clock_i  in   1  core clock; must be >=8x SCL
reset_bit_i       in   1  asynchronous, active-low reset
scl_i             in   1  raw SCL from pad
sda_i             in   1  raw SDA from pad
slave_addr_i      in   7  own address, static while busy_o=1
tx_data_i         in   8  byte to return on a master read
tx_valid_i        in   1  tx_data_i valid
tx_ready_o        out  1  1-cycle pulse: tx_data_i captured
sda_o             out  1  open-drain SDA drive: 0 = pull low, 1 = release
rx_data_o         out  8  last received data byte
rx_valid_o        out  1  1-cycle pulse: rx_data_o updated
rw_o              out  1  R/W bit of last matched address (1 = read)
addr_match_o      out  1  1-cycle pulse on address match
stop_o            out  1  1-cycle pulse on STOP detect
busy_o            out  1  1 from matched address until STOP/START
scl_o             out  1  open-drain SCL drive; present only with I2C_SLAVE_CLK_STRETCH_EN

Behaviour:
Reset values: sda_o=1, scl_o=1, rx_data_o=0, all pulses=0, rw_o=0, busy_o=0; FSM=IDLE, bit counter=7. The reset is asynchronous; sda_o releases immediately, even mid-ACK.

Line synchronisation and event detection:
- scl_s/sda_s come from SYNC_STAGES flops.
- Previous-value registers give scl_rise, scl_fall, sda_rise and sda_fall.
- START = sda_fall while scl_s=1.
- STOP = sda_rise while scl_s=1.
- Latency from pad edge to event is SYNC_STAGES+1 cycles.

FSM states: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, IGNORE.
- START (or repeated START) from any state: go to ADDR, counter=7, sda_o=1. START outranks every other event in the same cycle.
- STOP from any state: go to IDLE, sda_o=1, stop_o pulse, busy_o=0.
- ADDR: shift sda_s in on each scl_rise, MSB first. After the 8th rise, compare bits[7:1] with slave_addr_i.
  - Match: latch rw_o, pulse addr_match_o, set busy_o, go to ADDR_ACK.
  - Mismatch: go to IGNORE; sda_o is never driven.
- ADDR_ACK: on the next scl_fall drive sda_o=0.
  - Following scl_fall with rw=0: release sda_o, go to RX_DATA.
  - Following scl_fall with rw=1: load the TX byte, drive its MSB, go to TX_DATA.
  - In the same cycle as the TX-byte load, pulse tx_ready_o if tx_valid_i=1; otherwise use IDLE_FILL.
- RX_DATA: sample on scl_rise, counter 7 down to 0. After bit 0, rx_data_o is updated and rx_valid_o pulses in the same cycle; go to RX_ACK. RX_ACK drives ACK on the next fall and releases on the following fall, then returns to RX_DATA.
- TX_DATA: on each scl_fall present the next bit. After 8 bits, release sda_o at the 9th fall and go to TX_ACK.
- TX_ACK: sample the master's bit on scl_rise.
  - 0 (ACK): load the next byte at the following fall and return to TX_DATA.
  - 1 (NACK): go to IGNORE.
- IGNORE: sda_o=1; wait for START/STOP.

Boundary rules:
- sda_o changes only one cycle after a detected scl_fall, never while scl_s=1, except release on START/STOP/reset.
- A STOP or START mid-byte discards the partial byte; no rx_valid_o pulse.
- Counter wrap: after bit 0 the counter reloads to 7 at ACK exit.

Optional Feature:
I2C_SLAVE_CLK_STRETCH_EN.
- Defined: adds scl_o. When a TX byte load is due and tx_valid_i=0, hold scl_o=0 from that scl_fall until tx_valid_i=1. Then capture the byte, drive its MSB, and release scl_o one cycle later. START/STOP/reset release scl_o.
- Undefined: no scl_o port; IDLE_FILL is sent in place of the missing byte.

Decomposition:
- Package i2c_slave_pkg: FSM state encoding, ACK=1'b0 / NACK=1'b1, I2C_ADDR_W=7, I2C_BYTE_W=8.
- One sub-module, i2c_slave_line_sync: synchronisers plus scl_rise/scl_fall/start/stop detect.

Test Plan:
1. slave_addr_i=7'h3C; master writes START, 0x78, 0xA5, STOP -> ACK (sda_o=0) on both 9th clocks; addr_match_o pulses with rw_o=0; rx_data_o=0xA5 with one rx_valid_o pulse; stop_o pulses.
2. Master sends 0x79 then reads two bytes, ACK then NACK, with tx_data_i=0x5A then 0xC3 -> bus sees 0x5A, 0xC3; two tx_ready_o pulses; IGNORE after NACK; sda_o=1.
3. Address 0x7A (0x3D+W) -> no ACK (sda_o stays 1); addr_match_o=0; state IGNORE until STOP.
4. Repeated START after 4 data bits, then 0x79 -> partial byte dropped (no rx_valid_o); new transaction ACKed with rw_o=1.
5. reset_bit_i low while sda_o=0 during ACK -> sda_o=1 the same instant; FSM IDLE; next START is handled normally.
6. Stretch build, read with tx_valid_i=0 for 20 cycles -> scl_o=0 until tx_valid_i rises, then the byte is sent. Non-stretch build, same stimulus -> 0xFF is sent.
